// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encodings, entry layout and constants for the instruction fetch front end
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int FETCH_DW = 32;
  typedef enum logic {FETCH_ST_IDLE = 1'b0, FETCH_ST_RUN = 1'b1} fetch_state_e;
  typedef struct packed {
    logic [31:0]         pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry skid FIFO with flush; head shows zero when empty
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int W = $bits(fetch_entry_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [1:0]   count_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  logic [W-1:0] mem_q [2];
  logic [1:0]   count_q, count_d;
  logic         head_q, head_d, wr;
  always_comb begin
    wr      = head_q ^ count_q[0];
    count_d = flush_i ? 2'd0 : count_q + 2'(push_i) - 2'(pop_i);
    head_d  = flush_i ? 1'b0 : head_q ^ pop_i;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr] <= data_i;
  end
  // The credit logic upstream must never let a read land in a full FIFO
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push_i && full_o && !pop_i && !flush_i));
  end
  assign count_o = count_q;
  assign full_o  = count_q == 2'd2;
  assign empty_o = count_q == 2'd0;
  assign head_o  = empty_o ? '0 : mem_q[head_q];
endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: fetches from a 1-cycle read SRAM by byte PC and streams {pc, instr} to decode
module imem_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  sram_csb,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [31:0]           out_pc
);
  localparam int W = 32 + DATA_WIDTH;
  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d, infl_pc_q, infl_pc_d;
  logic          infl_q, infl_d;
  logic          run, pop, push, issue;
  logic [1:0]    fifo_count, occ;
  logic          fifo_full, fifo_empty;
  logic [W-1:0]  head;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH_ST_IDLE;
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
    end
  end
  // Occupancy after this cycle's pop plus the read in flight must leave room for a new read
  always_comb begin
    run       = state_q == FETCH_ST_RUN;
    out_valid = run & ~fifo_empty;
    pop       = out_valid & out_ready & ~redirect_valid;
    push      = infl_q & ~redirect_valid;
    occ       = fifo_count - 2'(pop) + 2'(infl_q);
    issue     = run & ~redirect_valid & ~fifo_full & (occ < 2'd2);
    sram_csb  = ~issue;
    sram_addr = pc_q[ADDR_WIDTH+1:2];
    state_d   = FETCH_ST_RUN;
    pc_d      = redirect_valid ? redirect_pc & ~32'(INSTR_BYTES - 1) :
                issue          ? pc_q + 32'(INSTR_BYTES) : pc_q;
    infl_d    = issue;
    infl_pc_d = issue ? pc_q : infl_pc_q;
  end
  fetch_skid_fifo #(.W(W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  ({infl_pc_q, sram_dout}),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );
  assign out_pc    = head[W-1:DATA_WIDTH];
  assign out_instr = head[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: scoreboard bench; expected stream is every sequential byte PC from the last reset/redirect
module tb_imem_fetch_unit;
  localparam logic [31:0] RPC = 32'h8;
  logic        clk = 0, rst_n = 0, redirect_valid = 0, out_ready = 0;
  logic [31:0] redirect_pc = 0, sram_dout = 0;
  logic        sram_csb, out_valid;
  logic [7:0]  sram_addr;
  logic [31:0] out_instr, out_pc;
  logic [31:0] mem [256];
  logic        cap_en = 0;
  logic [7:0]  cap_addr = 0;
  logic [63:0] exp_q [$];
  logic [63:0] e;
  logic [31:0] nxt_pc = RPC;
  int          want_v = -1, want_c = -1, tests = 0, fails = 0, idle_n = 0;

  always #5 clk = ~clk;

  imem_fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .sram_csb       (sram_csb),
    .sram_addr      (sram_addr),
    .sram_dout      (sram_dout),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // SRAM port model: address captured at the clock edge, data appears 1 time unit later and holds
  initial forever begin
    @(negedge clk);
    cap_en   = !sram_csb;
    cap_addr = sram_addr;
  end
  initial forever begin
    @(posedge clk);
    if (cap_en) begin
      #1;
      sram_dout = mem[cap_addr];
    end
  end

  initial forever begin
    @(negedge clk);
    if (want_v >= 0) begin
      tests++;
      if (out_valid !== want_v[0]) begin
        fails++;
        $display("FAIL valid_timing: out_valid=%b want %0d at %0t", out_valid, want_v, $time);
      end
    end
    if (want_c >= 0) begin
      tests++;
      if (sram_csb !== want_c[0]) begin
        fails++;
        $display("FAIL csb: sram_csb=%b want %0d at %0t", sram_csb, want_c, $time);
      end
    end
    if (out_valid === 1'b0) begin
      tests++;
      if ({out_pc, out_instr} !== 64'h0) begin
        fails++;
        $display("FAIL empty_head: pc=%h instr=%h want 0 at %0t", out_pc, out_instr, $time);
      end
    end
    if (rst_n && !redirect_valid && out_ready && out_valid === 1'b1) begin
      idle_n = 0;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL stream: unexpected pc=%h instr=%h at %0t", out_pc, out_instr, $time);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          fails++;
          $display("FAIL stream: got pc=%h instr=%h want pc=%h instr=%h at %0t",
                   out_pc, out_instr, e[63:32], e[31:0], $time);
        end
      end
    end else if (rst_n && !redirect_valid && out_ready) begin
      idle_n++;
      if (idle_n == 4) begin
        tests++;
        fails++;
        $display("FAIL stall: no output for %0d ready cycles at %0t", idle_n, $time);
      end
    end else if (!rst_n || redirect_valid) begin
      idle_n = 0;
    end
  end

  task automatic restart(input logic [31:0] p);
    exp_q.delete();
    nxt_pc = p & ~32'h3;
  endtask

  task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc,
                      input int wv, input int wc);
    rst_n = rst;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    want_v = wv;
    want_c = wc;
    if (!rst) restart(RPC);
    else if (rv) restart(rpc);
    while (exp_q.size() < 8) begin
      exp_q.push_back({nxt_pc, mem[(nxt_pc >> 2) % 256]});
      nxt_pc += 4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[2] = 32'hFB010113;
    mem[3] = 32'h04812623;
    mem[4] = 32'h05010413;
    mem[96] = 32'hED5FF06F;
    step(0, 1, 0, 0, -1, -1);
    step(0, 1, 0, 0, 0, 1);
    // reset release, first word three cycles later, then one per cycle
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 1, 0);
    // decode stall: FIFO fills, no further reads issued
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, -1, -1);
    // redirect with a read in flight
    step(1, 1, 1, 32'h180, -1, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, -1);
    step(1, 1, 0, 0, 1, -1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, -1);
    // unaligned target at the top of the array, then wrap to word 0
    step(1, 1, 1, 32'h3FE, -1, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, -1, -1);
    // reset with a full FIFO
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, -1, 1);
    step(0, 0, 0, 0, 1, -1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, -1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1, -1);
    // back-to-back redirects, last one wins
    step(1, 1, 1, 32'h40, -1, 1);
    step(1, 1, 1, 32'h80, 0, 1);
    step(1, 1, 1, 32'hC0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, -1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1, -1);
    for (int i = 0; i < 600; i++)
      step(($urandom % 100) != 0, ($urandom % 4) != 0, ($urandom % 12) == 0, $urandom, -1, -1);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
